aes_s3_job_arbiter: RTL

Round-robin arbiter that shares one AES stage-three accelerator core among NUM_REQ requester channels. Each requester submits a job of BEATS_PER_JOB 128-bit beats: data block first, then round keys 6..9. The block locks the core to one requester from the first beat until that job's response is delivered, then routes the response back. A watchdog recovers the arbiter if the core never responds.

---
 rtl/aes_s3_job_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/aes_s3_job_arbiter.sv
// Round-robin arbiter sharing one AES stage-three core among NUM_REQ requesters.
// A job is locked to its owner from the first beat until its response handshake or a watchdog abort.
module aes_s3_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 128,
    parameter int BEATS_PER_JOB  = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      core_in_valid,
    input  logic                      core_in_ready,
    output logic [DATA_W-1:0]         core_in_data,
    input  logic                      core_out_valid,
    output logic                      core_out_ready,
    input  logic [DATA_W-1:0]         core_out_data,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                      busy,
    output logic                      timeout_pulse,
    output logic                      stray_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(BEATS_PER_JOB) + 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(BEATS_PER_JOB - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [BC_W-1:0]  BC_MAX    = {BC_W{1'b1}};
    localparam logic [WD_W-1:0]  WD_MAX    = {WD_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0]       state_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] grant_id_r;
    logic [BC_W-1:0]  beat_cnt_r;
    logic [WD_W-1:0]  wd_cnt_r;
    logic             stray_err_r;
    logic             timeout_pulse_r;

    logic             hit_found_s;
    logic [IDX_W-1:0] hit_idx_s;
    logic [IDX_W-1:0] cand_idx_s;
    int               cand_s;
    logic             in_hs_s;
    logic             rsp_hs_s;
    logic             wd_expire_s;
    logic [IDX_W-1:0] next_ptr_s;

    // Cyclic search of req_valid starting at rr_ptr; first hit wins.
    always_comb begin
        hit_found_s = 1'b0;
        hit_idx_s   = '0;
        cand_s      = 0;
        cand_idx_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = int'(rr_ptr_r) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_W'(cand_s);
            if (!hit_found_s && req_valid[cand_idx_s]) begin
                hit_found_s = 1'b1;
                hit_idx_s   = cand_idx_s;
            end else begin
                hit_found_s = hit_found_s;
            end
        end
    end

    assign in_hs_s     = (state_r == ST_SEND) && req_valid[grant_id_r] && core_in_ready;
    assign rsp_hs_s    = (state_r == ST_WAIT) && core_out_valid && rsp_ready[grant_id_r];
    assign wd_expire_s = WD_EN && (state_r == ST_WAIT) && !rsp_hs_s && (wd_cnt_r == WD_LAST);
    assign next_ptr_s  = (grant_id_r == IDX_LAST) ? IDX_W'(0) : grant_id_r + IDX_W'(1);

    // Control state, round-robin pointer, counters and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            rr_ptr_r        <= '0;
            grant_id_r      <= '0;
            beat_cnt_r      <= '0;
            wd_cnt_r        <= '0;
            stray_err_r     <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            timeout_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (hit_found_s) begin
                        grant_id_r <= hit_idx_s;
                        state_r    <= ST_GRANT;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                    // Nobody owns the core, so any result here is unsolicited.
                    if (core_out_valid) begin
                        stray_err_r <= 1'b1;
                    end else begin
                        stray_err_r <= stray_err_r;
                    end
                end
                ST_GRANT: begin
                    beat_cnt_r <= '0;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    if (in_hs_s) begin
                        beat_cnt_r <= (beat_cnt_r == BC_MAX) ? beat_cnt_r : beat_cnt_r + BC_W'(1);
                        if (beat_cnt_r == BEAT_LAST) begin
                            state_r  <= ST_WAIT;
                            wd_cnt_r <= '0;
                        end else begin
                            state_r  <= ST_SEND;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_WAIT: begin
                    if (rsp_hs_s) begin
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_IDLE;
                    end else if (wd_expire_s) begin
                        timeout_pulse_r <= 1'b1;
                        rr_ptr_r        <= next_ptr_s;
                        state_r         <= ST_IDLE;
                    end else begin
                        wd_cnt_r <= (wd_cnt_r == WD_MAX) ? wd_cnt_r : wd_cnt_r + WD_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Datapath routing for the granted channel; everything is forced low while in reset.
    always_comb begin
        req_ready      = '0;
        rsp_valid      = '0;
        rsp_data       = '0;
        core_in_valid  = 1'b0;
        core_in_data   = '0;
        core_out_ready = 1'b0;
        if (rst) begin
            core_out_ready = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_out_ready = 1'b1;
                end
                ST_SEND: begin
                    core_in_valid         = req_valid[grant_id_r];
                    req_ready[grant_id_r] = core_in_ready;
                    core_in_data          = req_data[int'(grant_id_r)*DATA_W +: DATA_W];
                end
                ST_WAIT: begin
                    rsp_valid[grant_id_r] = core_out_valid;
                    rsp_data              = core_out_data;
                    core_out_ready        = rsp_ready[grant_id_r];
                end
                default: begin
                    core_out_ready = 1'b0;
                end
            endcase
        end
    end

    assign grant_id      = grant_id_r;
    assign busy          = (state_r != ST_IDLE);
    assign timeout_pulse = timeout_pulse_r;
    assign stray_err     = stray_err_r;

endmodule
